audio_sample_reader: RTL and testbench

AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

---
 rtl/audio_sample_reader.sv | 117 +++++++++++
 tb/tb_audio_sample_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_reader.sv
// audio_sample_reader: paces FIFO reads at the audio sample rate, with prefill/underrun handling.
// Optional feature macro AUDIO_UNDERRUN_MUTE_EN: output silence while not playing.
module audio_sample_reader #(
    parameter int PIXEL_TO_AUDIO_DIV = 1562,
    parameter int PREFILL_LEVEL      = 256
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic [31:0]      fifo_q,
    input  logic             fifo_empty,
    input  logic [10:0]      fifo_rnum,
    output logic             fifo_rden,
    output logic             clk_audio,
    output logic [1:0][15:0] audio_sample_word,
    output logic [15:0]      underrun_count,
    output logic [1:0]       state
);
    localparam int CW = $clog2(PIXEL_TO_AUDIO_DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(PIXEL_TO_AUDIO_DIV - 1);
    localparam logic [CW-1:0] HALF    = CW'(PIXEL_TO_AUDIO_DIV / 2);
    localparam logic [10:0]   LEVEL   = 11'(PREFILL_LEVEL);

    typedef enum logic [1:0] {PREFILL = 2'd0, PLAY = 2'd1, UNDERRUN = 2'd2} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_sync;
    logic [CW-1:0]    r_div;
    logic             r_clk_audio;
    logic             r_cap;
    logic             r_mute;
    logic [1:0][15:0] r_word;
    logic [15:0]      r_underrun_count;
    logic             w_run;
    logic             w_tick;
    logic             w_rdy;
    logic             w_rden;
    logic             w_uflow;
    logic             w_mute;

    assign w_run  = r_sync[1];
    assign w_tick = w_run && (r_div == '0);
    assign w_rdy  = !fifo_empty && (fifo_rnum >= LEVEL);

`ifdef AUDIO_UNDERRUN_MUTE_EN
    assign w_mute = w_tick && !w_rden;
`else
    assign w_mute = 1'b0;
`endif

    // Deassertion of reset_n is released to the logic only after two clk_pixel edges.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], 1'b1};
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n)   r_state <= PREFILL;
        else if (!w_run) r_state <= PREFILL;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_rden  = 1'b0;
        w_uflow = 1'b0;
        case (r_state)
            PREFILL, UNDERRUN: begin
                if (w_tick && w_rdy) begin
                    w_next = PLAY;
                    w_rden = 1'b1;
                end
            end
            PLAY: begin
                if (w_tick && fifo_empty) begin
                    w_next  = UNDERRUN;
                    w_uflow = 1'b1;
                end else if (w_tick) begin
                    w_rden = 1'b1;
                end
            end
            default: w_next = PREFILL;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_div            <= '0;
            r_clk_audio      <= 1'b0;
            r_cap            <= 1'b0;
            r_mute           <= 1'b0;
            r_word           <= '0;
            r_underrun_count <= '0;
        end else if (!w_run) begin
            r_div       <= '0;
            r_clk_audio <= 1'b0;
            r_cap       <= 1'b0;
            r_mute      <= 1'b0;
        end else begin
            r_div       <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
            r_clk_audio <= (r_div >= HALF);
            r_cap       <= w_rden;
            r_mute      <= w_mute;
            // FIFO data is valid the cycle after the read strobe.
            if (r_cap)       r_word <= fifo_q;
            else if (r_mute) r_word <= '0;
            if (w_uflow && r_underrun_count != 16'hFFFF)
                r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign fifo_rden         = w_rden;
    assign clk_audio         = r_clk_audio;
    assign audio_sample_word = r_word;
    assign underrun_count    = r_underrun_count;
    assign state             = r_state;
endmodule

// File: tb/tb_audio_sample_reader.sv
// tb_audio_sample_reader: directed checks of pacing, prefill, underrun, saturation and reset.
module tb_audio_sample_reader;
    logic             clk_pixel = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      fifo_q = 32'h0;
    logic             fifo_empty = 1'b1;
    logic [10:0]      fifo_rnum = 11'd0;
    logic             fifo_rden;
    logic             clk_audio;
    logic [1:0][15:0] audio_sample_word;
    logic [15:0]      underrun_count;
    logic [1:0]       state;

    int errors = 0;
    int checks = 0;
    int phase = 0;
    int stray = 0;
    int hi = 0;
    int rd = 0;
    logic clk_at4, clk_at5;

`ifdef AUDIO_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    audio_sample_reader #(.PIXEL_TO_AUDIO_DIV(8), .PREFILL_LEVEL(4)) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_rnum(fifo_rnum), .fifo_rden(fifo_rden), .clk_audio(clk_audio),
        .audio_sample_word(audio_sample_word), .underrun_count(underrun_count), .state(state)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_pixel);
        phase = (phase + 1) % 8;
    endtask

    task automatic run_to_tick();
        do begin
            cyc();
            #1;
            if (fifo_rden) stray++;
        end while (phase != 7);
        cyc();
    endtask

    initial begin
        #1;
        chk("rst_word", audio_sample_word, 32'h0);
        chk("rst_rden", {31'b0, fifo_rden}, 32'h0);
        chk("rst_clk", {31'b0, clk_audio}, 32'h0);
        chk("rst_state", {30'b0, state}, 32'h0);
        chk("rst_ucnt", {16'b0, underrun_count}, 32'h0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        phase = 0;
        #1;
        chk("c0_state", {30'b0, state}, 32'h0);
        chk("c0_clk", {31'b0, clk_audio}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            #1;
            if (fifo_rden) rd++;
            if (clk_audio) hi++;
            if (i == 3) clk_at4 = clk_audio;
            if (i == 4) clk_at5 = clk_audio;
        end
        chk("clk_high_cnt", hi, 8);
        chk("clk_ph4", {31'b0, clk_at4}, 32'h0);
        chk("clk_ph5", {31'b0, clk_at5}, 32'h1);
        chk("idle_rden", rd, 0);
        chk("idle_state", {30'b0, state}, 32'h0);
        // Prefill: one word short, then threshold reached.
        fifo_empty = 1'b0;
        fifo_rnum = 11'd3;
        #1;
        chk("pf3_rden", {31'b0, fifo_rden}, 32'h0);
        cyc();
        #1;
        chk("pf3_state", {30'b0, state}, 32'h0);
        run_to_tick();
        fifo_rnum = 11'd4;
        fifo_q = 32'h1234_5678;
        #1;
        chk("pf4_rden", {31'b0, fifo_rden}, 32'h1);
        cyc();
        #1;
        chk("pf4_state", {30'b0, state}, 32'h1);
        chk("pf4_rden_off", {31'b0, fifo_rden}, 32'h0);
        chk("pf4_word_pre", audio_sample_word, 32'h0);
        cyc();
        fifo_q = 32'h0BAD_0BAD;
        #1;
        chk("pf4_word", audio_sample_word, 32'h1234_5678);
        run_to_tick();
        chk("pf4_word_hold", audio_sample_word, 32'h1234_5678);
        // Play: data must be taken from the cycle after the strobe.
        fifo_q = 32'hDEAD_BEEF;
        #1;
        chk("play_rden", {31'b0, fifo_rden}, 32'h1);
        cyc();
        fifo_q = 32'hAAAA_5555;
        cyc();
        fifo_q = 32'h0BAD_0BAD;
        #1;
        chk("play_word", audio_sample_word, 32'hAAAA_5555);
        run_to_tick();
        // Underrun: empty wins over a sufficient fill level.
        fifo_empty = 1'b1;
        #1;
        chk("ur_rden", {31'b0, fifo_rden}, 32'h0);
        cyc();
        #1;
        chk("ur_state", {30'b0, state}, 32'h2);
        chk("ur_cnt", {16'b0, underrun_count}, 32'h1);
        cyc();
        #1;
        chk("ur_word", audio_sample_word, MUTE ? 32'h0 : 32'hAAAA_5555);
        run_to_tick();
        #1;
        chk("ur_empty_rden", {31'b0, fifo_rden}, 32'h0);
        cyc();
        #1;
        chk("ur_empty_state", {30'b0, state}, 32'h2);
        run_to_tick();
        fifo_empty = 1'b0;
        fifo_rnum = 11'd3;
        #1;
        chk("ur3_rden", {31'b0, fifo_rden}, 32'h0);
        cyc();
        #1;
        chk("ur3_state", {30'b0, state}, 32'h2);
        run_to_tick();
        fifo_rnum = 11'd4;
        #1;
        chk("ur4_rden", {31'b0, fifo_rden}, 32'h1);
        cyc();
        fifo_q = 32'h0102_0304;
        #1;
        chk("ur4_state", {30'b0, state}, 32'h1);
        cyc();
        #1;
        chk("ur4_word", audio_sample_word, 32'h0102_0304);
        chk("ur4_cnt", {16'b0, underrun_count}, 32'h1);
        run_to_tick();
        // Saturation: counter preloaded one short of full scale.
        force dut.r_underrun_count = 16'hFFFE;
        #1;
        release dut.r_underrun_count;
        fifo_empty = 1'b1;
        cyc();
        #1;
        chk("sat_first", {16'b0, underrun_count}, 32'hFFFF);
        run_to_tick();
        fifo_empty = 1'b0;
        #1;
        chk("sat_reread", {31'b0, fifo_rden}, 32'h1);
        run_to_tick();
        fifo_empty = 1'b1;
        cyc();
        #1;
        chk("sat_hold", {16'b0, underrun_count}, 32'hFFFF);
        chk("sat_state", {30'b0, state}, 32'h2);
        run_to_tick();
        // Reset the cycle after a read strobe: the in-flight word is dropped.
        fifo_empty = 1'b0;
        #1;
        chk("rr_rden", {31'b0, fifo_rden}, 32'h1);
        cyc();
        fifo_q = 32'hCAFE_F00D;
        reset_n = 1'b0;
        #1;
        chk("rr_word", audio_sample_word, 32'h0);
        chk("rr_state", {30'b0, state}, 32'h0);
        chk("rr_cnt", {16'b0, underrun_count}, 32'h0);
        chk("rr_rden_low", {31'b0, fifo_rden}, 32'h0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        fifo_rnum = 11'd3;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        phase = 0;
        #1;
        chk("rr_word_after", audio_sample_word, 32'h0);
        rd = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            #1;
            if (fifo_rden) rd++;
        end
        chk("rr_no_reads", rd, 0);
        chk("rr_state_after", {30'b0, state}, 32'h0);
        fifo_rnum = 11'd4;
        #1;
        chk("rr_resume_rden", {31'b0, fifo_rden}, 32'h1);
        chk("stray_reads", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
